// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the single-port RAM block
package ram_pkg;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int addr_w(input int depth);
    return depth <= 1 ? 1 : $clog2(depth);
  endfunction
  function automatic logic par_bit(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: INIT/RUN controller that zeroes every word once after reset
import ram_pkg::*;
module ram_clear_fsm #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready,
  output logic              done
);
  state_t state;
  logic last;
  assign last = clr_addr == ADDR_W'(DEPTH - 1);
  assign clr_we = state == INIT && !rst;
  // walk the clear pointer across all words, then hand over to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      clr_addr <= '0;
      ready    <= 1'b0;
      done     <= 1'b0;
    end else if (state == INIT) begin
      clr_addr <= last ? '0 : clr_addr + 1'b1;
      state    <= last ? RUN : INIT;
      ready    <= last;
      done     <= last;
    end
  end
endmodule

// File: rtl/ram_sp_param.sv
// ram_sp_param: single-port byte-enable RAM with clear-on-reset; optional parity via RAM_SP_PARITY_EN
import ram_pkg::*;
module ram_sp_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int NB = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [NB-1:0]     req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_perr,
  output logic              init_done
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range, acc, wr, rd, perr_now;
  logic [DATA_W-1:0] rd_word;
  ram_clear_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fsm (
    .clk(clk), .rst(rst), .clr_we(clr_we), .clr_addr(clr_addr),
    .ready(req_ready), .done(init_done)
  );
  assign in_range = 32'(req_addr) < DEPTH;
  assign acc      = req_valid && req_ready;
  assign wr       = acc && req_we && in_range;
  assign rd       = acc && !req_we;
  assign rd_word  = in_range ? mem[req_addr] : '0;
`ifdef RAM_SP_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  // flag any byte whose stored parity disagrees with its data
  always_comb begin
    perr_now = 1'b0;
    for (int i = 0; i < NB; i++)
      perr_now = perr_now | (in_range && par_bit(rd_word[8*i+:8]) != par_mem[req_addr][i]);
  end
  // clear or byte-merge data together with its per-byte parity
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr]     <= '0;
      par_mem[clr_addr] <= {NB{par_bit(8'h00)}};
    end else if (wr) begin
      for (int i = 0; i < NB; i++)
        if (req_be[i]) begin
          mem[req_addr][8*i+:8] <= req_wdata[8*i+:8];
          par_mem[req_addr][i]  <= par_bit(req_wdata[8*i+:8]);
        end
    end
  end
`else
  assign perr_now = 1'b0;
  // clear or byte-merge data
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (wr)
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[req_addr][8*i+:8] <= req_wdata[8*i+:8];
  end
`endif
  // one-cycle read response; data holds until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_perr  <= 1'b0;
    end else begin
      rsp_valid <= rd;
      rsp_err   <= rd && !in_range;
      rsp_perr  <= rd && perr_now;
      if (rd) rsp_rdata <= rd_word;
    end
  end
endmodule

// File: tb/tb_ram_sp_param.sv
// tb_ram_sp_param: directed checks of an 8x16 and a 32x12 instance sharing one request stream
module tb_ram_sp_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0, addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready0, rv0, err0, perr0, done0;
  logic [7:0]  rdata0;
  logic        ready1, rv1, err1, perr1, done1;
  logic [31:0] rdata1;
  int          total = 0, passed = 0, n, n1;
  logic        exp_perr;
  always #5 clk = ~clk;
  ram_sp_param #(.DATA_W(8), .DEPTH(16)) u0 (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready0), .req_we(we),
    .req_be(be[0]), .req_addr(addr), .req_wdata(wdata[7:0]), .rsp_valid(rv0),
    .rsp_rdata(rdata0), .rsp_err(err0), .rsp_perr(perr0), .init_done(done0)
  );
  ram_sp_param #(.DATA_W(32), .DEPTH(12)) u1 (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready1), .req_we(we),
    .req_be(be), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv1),
    .rsp_rdata(rdata1), .rsp_err(err1), .rsp_perr(perr1), .init_done(done1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic req(input logic w, input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    valid = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(negedge clk);
    valid = 1'b0; we = 1'b0;
  endtask
  task automatic count_init();
    n = 0; n1 = 0;
    do begin
      @(negedge clk);
      n++;
      if (ready1 && n1 == 0) n1 = n;
      if (n == 3) begin valid = 1'b1; we = 1'b1; addr = 4'h0; be = 4'hF; wdata = 32'h77777777; end
      if (n == 4) begin valid = 1'b0; we = 1'b0; end
    end while (!ready0 && n < 40);
    valid = 1'b0; we = 1'b0;
    chk("init_cycles0", 32'(n), 32'd16);
    chk("init_cycles1", 32'(n1), 32'd12);
    chk("init_done0", {31'h0, done0}, 32'd1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, ready0}, 32'd0);
    chk("rst_done", {31'h0, done0}, 32'd0);
    chk("rst_rvalid", {31'h0, rv0}, 32'd0);
    chk("rst_rdata", {24'h0, rdata0}, 32'd0);
    chk("rst_err_perr", {30'h0, err0, perr0}, 32'd0);
    rst = 1'b0;
    count_init();
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1; we = 1'b0; addr = 4'(i);
      @(negedge clk);
      chk($sformatf("clr_rv0_%0d", i), {31'h0, rv0}, 32'd1);
      chk($sformatf("clr_data0_%0d", i), {24'h0, rdata0}, 32'd0);
      chk($sformatf("clr_err1_%0d", i), {31'h0, err1}, {31'h0, i >= 12});
    end
    valid = 1'b0;
    @(negedge clk);
    chk("strobe_drop", {30'h0, rv0, err1}, 32'd0);
    req(1'b1, 4'd3, 4'hF, 32'h000000A5);
    chk("wr_no_rsp", {31'h0, rv0}, 32'd0);
    req(1'b0, 4'd3, 4'hF, 32'h0);
    chk("raw_rv", {31'h0, rv0}, 32'd1);
    chk("raw_data0", {24'h0, rdata0}, 32'hA5);
    chk("raw_err0", {31'h0, err0}, 32'd0);
    req(1'b1, 4'd5, 4'hF, 32'h11223344);
    req(1'b1, 4'd5, 4'b0101, 32'hFFFFFFFF);
    req(1'b0, 4'd5, 4'h0, 32'h0);
    chk("be_merge1", rdata1, 32'h11FF33FF);
    chk("be_merge0", {24'h0, rdata0}, 32'hFF);
    @(negedge clk);
    chk("rdata_hold", rdata1, 32'h11FF33FF);
    req(1'b1, 4'd1, 4'hF, 32'hCAFEBABE);
    req(1'b0, 4'd13, 4'h0, 32'h0);
    chk("oor_rd_data1", rdata1, 32'h0);
    chk("oor_rd_err1", {31'h0, err1}, 32'd1);
    chk("inr_rd_err0", {31'h0, err0}, 32'd0);
    req(1'b1, 4'd13, 4'hF, 32'hDEADBEEF);
    req(1'b0, 4'd1, 4'h0, 32'h0);
    chk("oor_wr_keep1", rdata1, 32'hCAFEBABE);
    chk("oor_wr_keep0", {24'h0, rdata0}, 32'hBE);
    req(1'b0, 4'd13, 4'h0, 32'h0);
    chk("oor_wr_ign1", rdata1, 32'h0);
    chk("inr_wr13_0", {24'h0, rdata0}, 32'hEF);
`ifdef RAM_SP_PARITY_EN
    u0.par_mem[2][0] = ~u0.par_mem[2][0];
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    req(1'b0, 4'd2, 4'h0, 32'h0);
    chk("perr0", {31'h0, perr0}, {31'h0, exp_perr});
    chk("perr1", {31'h0, perr1}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_init_ready", {31'h0, ready0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_init();
    req(1'b0, 4'd0, 4'h0, 32'h0);
    chk("init_wr_ign0", {24'h0, rdata0}, 32'd0);
    chk("init_wr_ign1", rdata1, 32'd0);
    req(1'b0, 4'd3, 4'h0, 32'h0);
    chk("reclear0", {24'h0, rdata0}, 32'd0);
    valid = 1'b1; we = 1'b0; addr = 4'd5; rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_rv", {30'h0, rv0, rv1}, 32'd0);
    chk("rst_rd_rdata", rdata1, 32'd0);
    valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_rv2", {30'h0, rv0, rv1}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
